// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: grants one of two requesters access to a shared
// combinational ALU and returns the result tagged with the winner's ID.
// Round-robin priority alternates between requesters. Every output is a
// flop, so there is no combinational path from any requester input.
module alu_share_ctrl #(
  parameter int unsigned W   = 4,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_vld,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ack,
  input  logic           req1_vld,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ack,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_cout,
  output logic           rsp_vld,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_cout,
  output logic           busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic           r_pri;
  logic           r_win_id;
  logic           r_ack0;
  logic           r_ack1;
  logic           r_rsp_vld;
  logic           r_busy;
  logic [OPW-1:0] r_alu_op;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [W-1:0]   r_rsp_y;
  logic           r_rsp_cout;
  logic           r_rsp_id;

  logic           w_any;
  logic           w_pick;
  logic           w_grant;
  logic           w_capture;
  logic           w_ack0_nxt;
  logic           w_ack1_nxt;
  logic           w_rsp_vld_nxt;
  logic           w_busy_nxt;

  // Winner selection: a lone requester always wins, otherwise r_pri decides.
  assign w_any  = req0_vld | req1_vld;
  assign w_pick = (req0_vld & req1_vld) ? r_pri : req1_vld;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the next values of the registered strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ack0_nxt    = w_grant & ~w_pick;
    w_ack1_nxt    = w_grant & w_pick;
    w_rsp_vld_nxt = w_capture;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  // Strobe registers: ack during EXEC, rsp_vld during RESP, busy outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack0    <= w_ack0_nxt;
      r_ack1    <= w_ack1_nxt;
      r_rsp_vld <= w_rsp_vld_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // ALU operand registers and winner ID: loaded only on a grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_win_id <= 1'b0;
    end else if (w_grant) begin
      r_alu_op <= w_pick ? req1_op : req0_op;
      r_alu_a  <= w_pick ? req1_a  : req0_a;
      r_alu_b  <= w_pick ? req1_b  : req0_b;
      r_win_id <= w_pick;
    end
  end

  // Result capture at the end of EXEC; the loser takes priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_y    <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_pri      <= 1'b0;
    end else if (w_capture) begin
      r_rsp_y    <= alu_y;
      r_rsp_cout <= alu_cout;
      r_rsp_id   <= r_win_id;
      r_pri      <= ~r_win_id;
    end
  end

  assign req0_ack = r_ack0;
  assign req1_ack = r_ack1;
  assign alu_op   = r_alu_op;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_id   = r_rsp_id;
  assign rsp_y    = r_rsp_y;
  assign rsp_cout = r_rsp_cout;
  assign busy     = r_busy;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small 16-function ALU model.
module tb_alu_share_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req0_vld, req1_vld;
  logic [3:0] req0_op, req0_a, req0_b;
  logic [3:0] req1_op, req1_a, req1_b;
  logic       req0_ack, req1_ack;
  logic [3:0] alu_op, alu_a, alu_b, alu_y;
  logic       alu_cout;
  logic       rsp_vld, rsp_id, rsp_cout, busy;
  logic [3:0] rsp_y;
  logic [4:0] alu_s;

  int total;
  int bad;
  int cnt0;
  int cnt1;
  int fid;

  alu_share_ctrl #(.W(4), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ack(req0_ack),
    .req1_vld(req1_vld), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ack(req1_ack),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: 0=AND, 1=ADD, 2=SUB, 3=OR, others XOR.
  always_comb begin
    alu_s = '0;
    case (alu_op)
      4'h0:    alu_s = {1'b0, alu_a & alu_b};
      4'h1:    alu_s = 5'(alu_a) + 5'(alu_b);
      4'h2:    alu_s = 5'(alu_a) - 5'(alu_b);
      4'h3:    alu_s = {1'b0, alu_a | alu_b};
      default: alu_s = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_y    = alu_s[3:0];
  assign alu_cout = alu_s[4];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack0"},  8'(req0_ack), 8'h0);
    chk({tag, "_ack1"},  8'(req1_ack), 8'h0);
    chk({tag, "_aop"},   8'(alu_op),   8'h0);
    chk({tag, "_aa"},    8'(alu_a),    8'h0);
    chk({tag, "_ab"},    8'(alu_b),    8'h0);
    chk({tag, "_rvld"},  8'(rsp_vld),  8'h0);
    chk({tag, "_rid"},   8'(rsp_id),   8'h0);
    chk({tag, "_ry"},    8'(rsp_y),    8'h0);
    chk({tag, "_rcout"}, 8'(rsp_cout), 8'h0);
    chk({tag, "_busy"},  8'(busy),     8'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    total = 0; bad = 0; cnt0 = 0; cnt1 = 0; fid = 0;
    rst_n = 1'b0;
    req0_vld = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_vld = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    #2;
    chk_reset_vals("rst");
    do_reset();

    // Single AND op from requester 0.
    req0_vld = 1'b1; req0_op = 4'h0; req0_a = 4'hC; req0_b = 4'hA;
    step();
    chk("s_ack0", 8'(req0_ack), 8'h1);
    chk("s_ack1", 8'(req1_ack), 8'h0);
    chk("s_busy", 8'(busy), 8'h1);
    chk("s_aop",  8'(alu_op), 8'h0);
    chk("s_aa",   8'(alu_a), 8'hC);
    chk("s_ab",   8'(alu_b), 8'hA);
    chk("s_rvld0", 8'(rsp_vld), 8'h0);
    req0_vld = 1'b0;
    step();
    chk("s_rvld", 8'(rsp_vld), 8'h1);
    chk("s_rid",  8'(rsp_id), 8'h0);
    chk("s_ry",   8'(rsp_y), 8'h8);
    chk("s_rc",   8'(rsp_cout), 8'h0);
    chk("s_ack0b", 8'(req0_ack), 8'h0);
    chk("s_busy2", 8'(busy), 8'h1);
    step();
    chk("s_idle_rvld", 8'(rsp_vld), 8'h0);
    chk("s_idle_busy", 8'(busy), 8'h0);

    // Simultaneous requests right after reset: requester 0 first.
    do_reset();
    req0_vld = 1'b1; req0_op = 4'h0; req0_a = 4'hF; req0_b = 4'h3;
    req1_vld = 1'b1; req1_op = 4'h0; req1_a = 4'h5; req1_b = 4'hF;
    step();
    chk("d_ack0", 8'(req0_ack), 8'h1);
    chk("d_ack1", 8'(req1_ack), 8'h0);
    req0_vld = 1'b0;
    step();
    chk("d_rvld0", 8'(rsp_vld), 8'h1);
    chk("d_rid0",  8'(rsp_id), 8'h0);
    chk("d_ry0",   8'(rsp_y), 8'h3);
    chk("d_ack1q", 8'(req1_ack), 8'h0);
    step();
    chk("d_ack1b", 8'(req1_ack), 8'h1);
    chk("d_ack0b", 8'(req0_ack), 8'h0);
    chk("d_aa1",   8'(alu_a), 8'h5);
    req1_vld = 1'b0;
    step();
    chk("d_rvld1", 8'(rsp_vld), 8'h1);
    chk("d_rid1",  8'(rsp_id), 8'h1);
    chk("d_ry1",   8'(rsp_y), 8'h5);
    step();
    chk("d_busy", 8'(busy), 8'h0);

    // Fairness: both held for 8 grants, ADD with distinct operands.
    req0_vld = 1'b1; req0_op = 4'h1; req0_a = 4'h3; req0_b = 4'h4;
    req1_vld = 1'b1; req1_op = 4'h1; req1_a = 4'h9; req1_b = 4'h9;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("f_busy", 8'(busy), 8'h1);
      if ((c % 2) == 1) begin
        fid = ((c - 1) / 2) % 2;
        chk("f_ack0", 8'(req0_ack), (fid == 0) ? 8'h1 : 8'h0);
        chk("f_ack1", 8'(req1_ack), (fid == 1) ? 8'h1 : 8'h0);
        chk("f_rvld_off", 8'(rsp_vld), 8'h0);
      end else begin
        fid = ((c - 2) / 2) % 2;
        chk("f_rvld", 8'(rsp_vld), 8'h1);
        chk("f_rid",  8'(rsp_id), 8'(fid));
        chk("f_ry",   8'(rsp_y), (fid == 1) ? 8'h2 : 8'h7);
        chk("f_rc",   8'(rsp_cout), (fid == 1) ? 8'h1 : 8'h0);
        chk("f_ackq", 8'({req1_ack, req0_ack}), 8'h0);
        if (rsp_vld) begin
          if (rsp_id) cnt1++;
          else        cnt0++;
        end
      end
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    chk("f_cnt0", 8'(cnt0), 8'h4);
    chk("f_cnt1", 8'(cnt1), 8'h4);
    step();
    chk("f_end_busy", 8'(busy), 8'h0);

    // Carry path: 0xF + 0x1 from requester 0.
    req0_vld = 1'b1; req0_op = 4'h1; req0_a = 4'hF; req0_b = 4'h1;
    step();
    chk("c_ack0", 8'(req0_ack), 8'h1);
    req0_vld = 1'b0;
    step();
    chk("c_rvld", 8'(rsp_vld), 8'h1);
    chk("c_rid",  8'(rsp_id), 8'h0);
    chk("c_ry",   8'(rsp_y), 8'h0);
    chk("c_rc",   8'(rsp_cout), 8'h1);

    // Idle hold: ALU regs keep last values, strobes stay low.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("i_aop",  8'(alu_op), 8'h1);
      chk("i_aa",   8'(alu_a), 8'hF);
      chk("i_ab",   8'(alu_b), 8'h1);
      chk("i_strb", 8'({busy, rsp_vld, req1_ack, req0_ack}), 8'h0);
    end

    // Reset in EXEC while requester 1 is served and priority points at 1.
    req1_vld = 1'b1; req1_op = 4'h2; req1_a = 4'h6; req1_b = 4'h2;
    step();
    chk("r_ack1", 8'(req1_ack), 8'h1);
    chk("r_busy", 8'(busy), 8'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("r_async");
    req1_vld = 1'b0;
    step();
    chk("r_rvld_a", 8'(rsp_vld), 8'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_post_rvld", 8'(rsp_vld), 8'h0);
      chk("r_post_ack",  8'({req1_ack, req0_ack}), 8'h0);
    end
    req0_vld = 1'b1; req0_op = 4'h3; req0_a = 4'h8; req0_b = 4'h1;
    req1_vld = 1'b1; req1_op = 4'h0; req1_a = 4'h7; req1_b = 4'h7;
    step();
    chk("r_ack0", 8'(req0_ack), 8'h1);
    chk("r_ack1b", 8'(req1_ack), 8'h0);
    chk("r_aa", 8'(alu_a), 8'h8);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    step();
    chk("r_rvld", 8'(rsp_vld), 8'h1);
    chk("r_rid",  8'(rsp_id), 8'h0);
    chk("r_ry",   8'(rsp_y), 8'h9);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-port round-robin arbiter that shares the single 4-bit, 16-function combinational ALU between two requesters. Each requester posts an opcode plus two operands. The controller grants one requester, drives the ALU from registered operands and captures the ALU result and carry-out. It then returns the result tagged with the winner's ID. The block sits between the requesting control logic and the ALU top level; the ALU itself stays purely combinational and outside this block.

## Interface
- W, 4, operand/result width (ALU datapath width)
- OPW, 4, opcode width (16 functions)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_vld  in  1  requester 0 has an operation pending; held until req0_ack
- req0_op  in  OPW  requester 0 opcode; stable while req0_vld=1
- req0_a, req0_b  in  W  requester 0 operands; stable while req0_vld=1
- req0_ack  out  1  one-cycle accept pulse to requester 0
- req1_vld, req1_op, req1_a, req1_b, req1_ack  same as requester 0, for requester 1
- alu_op  out  OPW  registered opcode to ALU
- alu_a, alu_b  out  W  registered operands to ALU
- alu_y  in  W  ALU result, combinational from alu_*
- alu_cout  in  1  ALU carry/borrow out
- rsp_vld  out  1  one-cycle result strobe
- rsp_id  out  1  requester that owns rsp_y (0/1)
- rsp_y  out  W  captured result
- rsp_cout  out  1  captured carry
- busy  out  1  1 in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Encoding is free. Reset state is IDLE.
- IDLE: at a clock edge with any reqN_vld=1:
  - pick a winner by priority pointer `pri`.
  - load alu_op/alu_a/alu_b from the winner.
  - record win_id.
  - go to EXEC.
  - With no request, stay in IDLE.
- EXEC: reqN_ack=1 for win_id only. The ALU settles within this cycle. At the closing edge:
  - capture alu_y→rsp_y and alu_cout→rsp_cout, with rsp_id←win_id.
  - set pri←~win_id.
  - go to RESP.
- RESP: rsp_vld=1. Arbitration is identical to IDLE: a request present at the closing edge loads the ALU regs and goes to EXEC; otherwise the FSM goes to IDLE.
- Arbitration:
  - Only one requester valid: that requester wins, regardless of pri.
  - Both valid: requester `pri` wins.
  - pri resets to 0, so requester 0 is favoured first.
  - After each grant, the loser gets priority. Two continuously-valid requesters therefore alternate 0,1,0,1.
- Requester obligation: drop reqN_vld, or present a new operation, in the cycle after reqN_ack. A requester that still holds vld there is treated as a new request.
- Width rules:
  - Operands and opcode pass through unmodified, with no sign extension.
  - rsp_y is exactly W bits. Carry is reported only via rsp_cout.
- alu_op/alu_a/alu_b hold their last loaded value outside EXEC. They change only on a grant edge.
- rsp_y/rsp_cout/rsp_id hold until the next capture. They are valid to sample only when rsp_vld=1.
- Async reset mid-operation:
  - FSM→IDLE immediately; the pending operation is dropped.
  - No ack or rsp_vld is produced for it.
  - pri→0.

## Timing
- Reset values: req0_ack=0, req1_ack=0, alu_op=0, alu_a=0, alu_b=0, rsp_vld=0, rsp_id=0, rsp_y=0, rsp_cout=0, busy=0.
- All outputs are registered or decoded from state only. There is no combinational path from reqN_* to any output.
- Latency:
  - Request sampled at edge E0 → ack and ALU drive during cycle E0..E1.
  - rsp_vld during cycle E1..E2.
  - Request→response is 2 cycles.
- Throughput: one operation per 2 cycles sustained (RESP overlaps the next grant). busy stays 1 under back-to-back load.
- ack and rsp_vld are each exactly one cycle wide and never assert for both requesters at once.
- The ALU combinational delay must fit within one clk period (EXEC cycle).

## Test plan
- Single op, bench ALU model op 4'h0 = AND:
  - Stimulus: req0_vld=1, op=4'h0, a=4'hC, b=4'hA.
  - Response: req0_ack one cycle later; rsp_vld the following cycle with rsp_id=0, rsp_y=4'h8, rsp_cout=0.
- Simultaneous requests out of reset:
  - Stimulus: req0 op 4'h0 (a=4'hF, b=4'h3) and req1 op 4'h0 (a=4'h5, b=4'hF).
  - Response: req0 granted first (rsp_y=4'h3, id=0); req1 next (rsp_y=4'h5, id=1); ack pulses 2 cycles apart.
- Fairness: both vld held for 8 grants → ids alternate 0,1,0,1,…; each requester receives exactly 4 responses; busy stays 1 throughout.
- Carry path, bench op 4'h1 = ADD: a=4'hF, b=4'h1 → rsp_y=4'h0, rsp_cout=1.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during EXEC.
  - Response: all outputs return to reset values asynchronously; no rsp_vld after release; the first post-reset simultaneous request grants req0.
- Idle hold: no requests for 10 cycles → alu_* keep their last values; ack, rsp_vld and busy stay 0.
